// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the ALU datapath sequencer.
// Holds the state encoding, the registered control word and its state decode.
package alu_seq_pkg;

   localparam int DATA_W   = 16;
   localparam int SEL_W    = 3;
   localparam int IDLE_SEL = 0;

   typedef enum logic [2:0] {
      IDLE,
      LD_A,
      LD_B,
      EXEC,
      WB,
      RESP
   } state_t;

   typedef struct packed {
      logic req_ready;
      logic rsp_valid;
      logic r0en;
      logic r1en;
      logic r2en;
      logic alu_out_en;
      logic opnd_en;
      logic opnd_sel_b;
      logic sel_en;
      logic capture_en;
   } ctrl_t;

   // One bus driver at most per state; a chained LD_A borrows the result tristate instead of the operand.
   function automatic ctrl_t decode(input state_t s, input logic chain);
      ctrl_t c;
      c = '0;
      unique case (s)
         IDLE: c.req_ready = 1'b1;
         LD_A: begin
            c.r0en   = 1'b1;
            c.sel_en = 1'b1;
            if (chain) c.alu_out_en = 1'b1;
            else       c.opnd_en    = 1'b1;
         end
         LD_B: begin
            c.r1en       = 1'b1;
            c.opnd_en    = 1'b1;
            c.opnd_sel_b = 1'b1;
            c.sel_en     = 1'b1;
         end
         EXEC: begin
            c.r2en   = 1'b1;
            c.sel_en = 1'b1;
         end
         WB: begin
            c.alu_out_en = 1'b1;
            c.capture_en = 1'b1;
            c.sel_en     = 1'b1;
         end
         RESP:    c.rsp_valid = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the host logic and the ALU sequencer.
interface alu_seq_if
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = alu_seq_pkg::DATA_W,
   parameter int SEL_W  = alu_seq_pkg::SEL_W
);

   logic              req_valid;
   logic              req_ready;
   logic [SEL_W-1:0]  req_sel;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;
   logic              req_chain;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output req_valid, req_sel, req_a, req_b, req_chain, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_sel, req_a, req_b, req_chain, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/alu_seq_fsm.sv
// Sequencer state machine; every control output is a flop loaded from the decode of the next state.
// Chained operand A is built in only when ALU_SEQ_CHAIN_EN is defined.
module alu_seq_fsm
   import alu_seq_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  req_valid,
   input  logic  req_chain,
   input  logic  rsp_ready,
   output ctrl_t ctrl
);

`ifdef ALU_SEQ_CHAIN_EN
   localparam bit CHAIN_EN = 1'b1;
`else
   localparam bit CHAIN_EN = 1'b0;
`endif

   state_t state;
   state_t state_nx;
   ctrl_t  ctrl_nx;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         ctrl  <= decode(IDLE, 1'b0);
      end else begin
         state <= state_nx;
         ctrl  <= ctrl_nx;
      end
   end

   // LD_A is entered only from IDLE, so the live req_chain is the value being accepted.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (req_valid) state_nx = LD_A;
         LD_A:    state_nx = LD_B;
         LD_B:    state_nx = EXEC;
         EXEC:    state_nx = WB;
         WB:      state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      ctrl_nx = decode(state_nx, req_chain && CHAIN_EN);
   end

endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer for the ALU datapath: latches one request, steps the datapath enables, returns the bus result.
// Define ALU_SEQ_CHAIN_EN to let a request reuse the previous result as operand A.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = alu_seq_pkg::DATA_W,
   parameter int SEL_W  = alu_seq_pkg::SEL_W
)(
   input  logic              clk,
   input  logic              rst,
   alu_seq_if.slave          host,
   output logic [DATA_W-1:0] opnd_out,
   output logic              opnd_en,
   input  logic [DATA_W-1:0] bus,
   output logic              r0en,
   output logic              r1en,
   output logic              r2en,
   output logic              aluOutEn,
   output logic [SEL_W-1:0]  ALU_Sel
);

   ctrl_t             ctrl;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [SEL_W-1:0]  sel_q;
   logic [DATA_W-1:0] rsp_data_q;

   alu_seq_fsm u_fsm (
      .clk       (clk),
      .rst       (rst),
      .req_valid (host.req_valid),
      .req_chain (host.req_chain),
      .rsp_ready (host.rsp_ready),
      .ctrl      (ctrl)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q   <= '0;
         b_q   <= '0;
         sel_q <= '0;
      end else if (ctrl.req_ready && host.req_valid) begin
         a_q   <= host.req_a;
         b_q   <= host.req_b;
         sel_q <= host.req_sel;
      end
   end

   // The result register only moves on the WB edge, so it stays put while RESP waits.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rsp_data_q <= '0;
      end else if (ctrl.capture_en) begin
         rsp_data_q <= bus;
      end
   end

   assign host.req_ready = ctrl.req_ready;
   assign host.rsp_valid = ctrl.rsp_valid;
   assign host.rsp_data  = rsp_data_q;

   assign opnd_en  = ctrl.opnd_en;
   assign opnd_out = !ctrl.opnd_en ? '0 : (ctrl.opnd_sel_b ? b_q : a_q);
   assign r0en     = ctrl.r0en;
   assign r1en     = ctrl.r1en;
   assign r2en     = ctrl.r2en;
   assign aluOutEn = ctrl.alu_out_en;
   assign ALU_Sel  = ctrl.sel_en ? sel_q : SEL_W'(IDLE_SEL);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural R0/R1/R2 datapath and shared bus.
// Build with ALU_SEQ_CHAIN_EN defined to exercise the chained-operand expectations.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] opnd_out;
   logic [15:0] bus;
   logic        opnd_en, r0en, r1en, r2en, aluOutEn;
   logic [2:0]  ALU_Sel;
   logic [15:0] r0 = '0;
   logic [15:0] r1 = '0;
   logic [15:0] r2 = '0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.DATA_W(16), .SEL_W(3)) host ();

   alu_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .host     (host),
      .opnd_out (opnd_out),
      .opnd_en  (opnd_en),
      .bus      (bus),
      .r0en     (r0en),
      .r1en     (r1en),
      .r2en     (r2en),
      .aluOutEn (aluOutEn),
      .ALU_Sel  (ALU_Sel)
   );

   function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
      case (s)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return {a[14:0], 1'b0};
         default: return b;
      endcase
   endfunction

   // An undriven bus reads as a marker value so a capture in the wrong cycle shows up.
   assign bus = opnd_en ? opnd_out : (aluOutEn ? r2 : 16'hDEAD);

   always @(posedge clk) begin
      if (r0en) r0 <= bus;
      if (r1en) r1 <= bus;
      if (r2en) r2 <= alu_model(r0, r1, ALU_Sel);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      host.req_valid = 1'b0;
      host.req_sel   = '0;
      host.req_a     = '0;
      host.req_b     = '0;
      host.req_chain = 1'b0;
      host.rsp_ready = 1'b0;
      rst = 1'b0;
      repeat (3) step();
      checks++;
      if ({r0en, r1en, r2en, aluOutEn, opnd_en, host.rsp_valid} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_enables got %b want 000000", {r0en, r1en, r2en, aluOutEn, opnd_en, host.rsp_valid});
      end
      checks++;
      if (host.req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_req_ready got %b want 1", host.req_ready);
      end
      checks++;
      if ({host.rsp_data, opnd_out, ALU_Sel} !== 35'h0) begin
         errors++;
         $display("[TB] FAIL reset_data got rsp_data=%h opnd_out=%h ALU_Sel=%0d want all 0", host.rsp_data, opnd_out, ALU_Sel);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_add();
      logic [6:0]  en_exp   [6];
      logic [15:0] opnd_exp [6];
      logic [6:0]  en_got;
      en_exp   = '{7'b1000100, 7'b0100100, 7'b0010000, 7'b0001000, 7'b0000001, 7'b0000010};
      opnd_exp = '{16'h0003, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      host.req_a     = 16'h0003;
      host.req_b     = 16'h0004;
      host.req_sel   = 3'b000;
      host.rsp_ready = 1'b1;
      host.req_valid = 1'b1;
      step();
      host.req_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         en_got = {r0en, r1en, r2en, aluOutEn, opnd_en, host.req_ready, host.rsp_valid};
         checks++;
         if (en_got !== en_exp[c]) begin
            errors++;
            $display("[TB] FAIL add_enables T+%0d got %b want %b", c + 1, en_got, en_exp[c]);
         end
         checks++;
         if (opnd_out !== opnd_exp[c]) begin
            errors++;
            $display("[TB] FAIL add_opnd_out T+%0d got %h want %h", c + 1, opnd_out, opnd_exp[c]);
         end
         if (c == 4) begin
            checks++;
            if (host.rsp_data !== 16'h0007) begin
               errors++;
               $display("[TB] FAIL add_result got %h want 0007", host.rsp_data);
            end
         end
         if (c < 5) step();
      end
   endtask

   task automatic test_reset_mid_exec();
      host.req_a     = 16'h0020;
      host.req_b     = 16'h0001;
      host.req_sel   = 3'b000;
      host.rsp_ready = 1'b1;
      host.req_valid = 1'b1;
      step();
      host.req_valid = 1'b0;
      step();
      step();
      checks++;
      if (r2en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_in_exec got r2en=%b want 1", r2en);
      end
      rst = 1'b0;
      step();
      rst = 1'b1;
      checks++;
      if ({r0en, r1en, r2en, aluOutEn, opnd_en, host.rsp_valid, host.req_ready} !== 7'b0000001) begin
         errors++;
         $display("[TB] FAIL midreset_outputs got %b want 0000001", {r0en, r1en, r2en, aluOutEn, opnd_en, host.rsp_valid, host.req_ready});
      end
      checks++;
      if (host.rsp_data !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL midreset_rsp_data got %h want 0000", host.rsp_data);
      end
      repeat (5) step();
      checks++;
      if (host.rsp_valid !== 1'b0 || host.req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_discard got rsp_valid=%b req_ready=%b want 0 1", host.rsp_valid, host.req_ready);
      end
   endtask

   task automatic test_hold();
      host.req_a     = 16'h0010;
      host.req_b     = 16'h0005;
      host.req_sel   = 3'b001;
      host.rsp_ready = 1'b0;
      host.req_valid = 1'b1;
      step();
      host.req_valid = 1'b0;
      checks++;
      if (ALU_Sel !== 3'b001) begin
         errors++;
         $display("[TB] FAIL hold_alu_sel got %0d want 1", ALU_Sel);
      end
      repeat (4) step();
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (host.rsp_valid !== 1'b1 || host.rsp_data !== 16'h000B || host.req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_stable cyc %0d got rsp_valid=%b rsp_data=%h req_ready=%b want 1 000B 0", k, host.rsp_valid, host.rsp_data, host.req_ready);
         end
         if (k == 2) begin
            host.req_valid = 1'b1;
            host.req_a     = 16'hFFFF;
         end
         if (k == 5) host.req_valid = 1'b0;
         step();
      end
      host.rsp_ready = 1'b1;
      step();
      checks++;
      if (host.req_ready !== 1'b1 || host.rsp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_release got req_ready=%b rsp_valid=%b want 1 0", host.req_ready, host.rsp_valid);
      end
      repeat (3) step();
      checks++;
      if (r0en !== 1'b0 || host.req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_not_queued got r0en=%b req_ready=%b want 0 1", r0en, host.req_ready);
      end
   endtask

   task automatic test_back_to_back();
      host.rsp_ready = 1'b1;
      host.req_a     = 16'h00FF;
      host.req_b     = 16'h0001;
      host.req_sel   = 3'b001;
      host.req_valid = 1'b1;
      step();
      host.req_a   = 16'h1000;
      host.req_b   = 16'h0010;
      host.req_sel = 3'b000;
      for (int c = 1; c <= 11; c++) begin
         if (c <= 5 || c >= 7) begin
            checks++;
            if (host.req_ready !== 1'b0) begin
               errors++;
               $display("[TB] FAIL b2b_req_ready T+%0d got %b want 0", c, host.req_ready);
            end
         end
         if (c == 1) begin
            checks++;
            if (opnd_out !== 16'h00FF) begin
               errors++;
               $display("[TB] FAIL b2b_first_opnd got %h want 00FF", opnd_out);
            end
         end
         if (c == 5) begin
            checks++;
            if (host.rsp_valid !== 1'b1 || host.rsp_data !== 16'h00FE) begin
               errors++;
               $display("[TB] FAIL b2b_first_result got valid=%b data=%h want 1 00FE", host.rsp_valid, host.rsp_data);
            end
         end
         if (c == 6) begin
            checks++;
            if (host.req_ready !== 1'b1) begin
               errors++;
               $display("[TB] FAIL b2b_reaccept got req_ready=%b want 1", host.req_ready);
            end
         end
         if (c == 7) begin
            checks++;
            if (r0en !== 1'b1 || opnd_out !== 16'h1000) begin
               errors++;
               $display("[TB] FAIL b2b_second_lda got r0en=%b opnd_out=%h want 1 1000", r0en, opnd_out);
            end
            host.req_valid = 1'b0;
         end
         if (c == 11) begin
            checks++;
            if (host.rsp_valid !== 1'b1 || host.rsp_data !== 16'h1010) begin
               errors++;
               $display("[TB] FAIL b2b_second_result got valid=%b data=%h want 1 1010", host.rsp_valid, host.rsp_data);
            end
         end
         step();
      end
   endtask

   task automatic test_chain();
      logic [2:0]  lda_exp;
      logic [15:0] res_exp;
`ifdef ALU_SEQ_CHAIN_EN
      lda_exp = 3'b101;
      res_exp = 16'h000F;
`else
      lda_exp = 3'b011;
      res_exp = 16'h010A;
`endif
      host.rsp_ready = 1'b1;
      host.req_a     = 16'h0002;
      host.req_b     = 16'h0003;
      host.req_sel   = 3'b000;
      host.req_chain = 1'b0;
      host.req_valid = 1'b1;
      step();
      host.req_valid = 1'b0;
      repeat (4) step();
      checks++;
      if (host.rsp_data !== 16'h0005) begin
         errors++;
         $display("[TB] FAIL chain_first_result got %h want 0005", host.rsp_data);
      end
      step();
      host.req_a     = 16'h0100;
      host.req_b     = 16'h000A;
      host.req_chain = 1'b1;
      host.req_valid = 1'b1;
      step();
      host.req_valid = 1'b0;
      host.req_chain = 1'b0;
      checks++;
      if ({aluOutEn, opnd_en, r0en} !== lda_exp) begin
         errors++;
         $display("[TB] FAIL chain_lda got aluOutEn/opnd_en/r0en=%b want %b", {aluOutEn, opnd_en, r0en}, lda_exp);
      end
      repeat (4) step();
      checks++;
      if (host.rsp_data !== res_exp) begin
         errors++;
         $display("[TB] FAIL chain_result got %h want %h", host.rsp_data, res_exp);
      end
      step();
   endtask

   task automatic test_random();
      logic [15:0] a, b, expv;
      logic [2:0]  sel;
      logic        done, accepted, hs_req, hs_rsp;
      for (int op = 0; op < 1000; op++) begin
         a    = 16'($urandom);
         b    = 16'($urandom);
         sel  = 3'($urandom_range(0, 7));
         expv = alu_model(a, b, sel);
         host.req_a     = a;
         host.req_b     = b;
         host.req_sel   = sel;
         host.req_chain = 1'b0;
         host.req_valid = 1'b1;
         host.rsp_ready = 1'b0;
         done     = 1'b0;
         accepted = 1'b0;
         for (int c = 0; c < 40 && !done; c++) begin
            checks++;
            if ((opnd_en && aluOutEn) !== 1'b0) begin
               errors++;
               $display("[TB] FAIL rand_two_drivers op %0d got opnd_en=%b aluOutEn=%b", op, opnd_en, aluOutEn);
            end
            checks++;
            if (!opnd_en && opnd_out !== 16'h0) begin
               errors++;
               $display("[TB] FAIL rand_opnd_idle op %0d got %h want 0000", op, opnd_out);
            end
            checks++;
            if ((host.req_ready || host.rsp_valid) && ALU_Sel !== 3'd0) begin
               errors++;
               $display("[TB] FAIL rand_alu_sel_idle op %0d got %0d want 0", op, ALU_Sel);
            end
            hs_req = host.req_ready && host.req_valid;
            hs_rsp = host.rsp_valid && host.rsp_ready;
            if (hs_rsp) begin
               checks++;
               if (host.rsp_data !== expv) begin
                  errors++;
                  $display("[TB] FAIL rand_result op %0d sel %0d a %h b %h got %h want %h", op, sel, a, b, host.rsp_data, expv);
               end
               done = 1'b1;
            end
            step();
            accepted = accepted || hs_req;
            if (accepted) begin
               host.req_valid = 1'($urandom_range(0, 1));
               host.req_a     = 16'($urandom);
               host.req_b     = 16'($urandom);
               host.req_sel   = 3'($urandom_range(0, 7));
            end
            host.rsp_ready = ($urandom_range(0, 3) != 0);
         end
         if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL rand_timeout op %0d no response within 40 cycles", op);
         end
      end
      host.req_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_reset_mid_exec();
      test_hold();
      test_back_to_back();
      test_chain();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
